// File: rtl/cla_pkg.sv
// Shared look-ahead helpers for the pipelined CLA: intra-group carry vector,
// group generate/propagate reduction and a configuration sanity check.
package cla_pkg;

  localparam int CLA_MAX_GS = 32;

  typedef logic [CLA_MAX_GS-1:0] grp_vec_t;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic bit cla_cfg_ok(input int n, input int gs);
    return (gs >= 2) && (gs <= CLA_MAX_GS) && (n >= gs) && ((n % gs) == 0);
  endfunction

  // c[i] is the carry out of bit i, expanded as a flat sum of products so
  // no bit waits on a rippled neighbour.
  function automatic grp_vec_t cla_carries(input grp_vec_t g, input grp_vec_t p,
                                           input logic cin, input int w);
    grp_vec_t c;
    logic     term;
    logic     pp;
    c = '0;
    for (int i = 0; i < CLA_MAX_GS; i++) begin
      if (i < w) begin
        term = 1'b0;
        pp   = 1'b1;
        for (int j = i; j >= 0; j--) begin
          term = term | (g[j] & pp);
          pp   = pp & p[j];
        end
        c[i] = term | (cin & pp);
      end
    end
    return c;
  endfunction

  function automatic gp_t cla_group_gp(input grp_vec_t g, input grp_vec_t p, input int w);
    gp_t      r;
    grp_vec_t c;
    c   = cla_carries(g, p, 1'b0, w);
    r.g = c[w-1];
    r.p = 1'b1;
    for (int i = 0; i < CLA_MAX_GS; i++) begin
      if (i < w) r.p = r.p & p[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GS-bit carry-look-ahead group: sum bits, group carry-out and
// the carry into the group MSB (used for signed overflow in the last group).
module cla_group
  import cla_pkg::*;
#(
  parameter int GS = 8
) (
  input  logic [GS-1:0] a,
  input  logic [GS-1:0] b,
  input  logic          cin,
  output logic [GS-1:0] sum,
  output logic          cout,
  output logic          c_msb_in
);

  grp_vec_t gv;
  grp_vec_t pv;
  grp_vec_t cv;
  gp_t      gp;
  logic     cv_unused;

  always_comb begin
    gv = '0;
    pv = '0;
    gv[GS-1:0] = a & b;
    pv[GS-1:0] = a ^ b;
    cv = cla_carries(gv, pv, cin, GS);
    gp = cla_group_gp(gv, pv, GS);
  end

  assign cout      = gp.g | (gp.p & cin);
  assign sum       = pv[GS-1:0] ^ {cv[GS-2:0], cin};
  assign c_msb_in  = cv[GS-2];
  // The group carry-out comes from G/P, so the top ripple carry is redundant.
  assign cv_unused = ^cv[CLA_MAX_GS-1:GS-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-look-ahead adder/subtractor: one GS-bit group per stage,
// inter-group carry registered, operands and partial sums skewed alongside.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int N  = 32,
  parameter int GS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int STG = N / GS;

  if (!cla_cfg_ok(N, GS)) begin : g_cfg_check
    $error("cla_pipe_adder: N must be a multiple of GS with 2 <= GS <= %0d", CLA_MAX_GS);
  end

  // Handshake: an op transfers on in_valid & in_ready, a result on
  // out_valid & out_ready. The whole pipe advances together whenever the
  // output slot is empty or being drained, so in_ready is that same condition.
  logic         adv;
  logic [N-1:0] b_eff;

  logic         v_in   [STG];
  logic         c_in   [STG];
  logic [N-1:0] a_in   [STG];
  logic [N-1:0] b_in   [STG];
  logic [N-1:0] s_in   [STG];

  logic         v_q    [STG];
  logic         c_q    [STG];
  logic [N-1:0] a_q    [STG];
  logic [N-1:0] b_q    [STG];
  logic [N-1:0] s_q    [STG];

  logic [GS-1:0] g_sum  [STG];
  logic          g_cout [STG];
  logic          g_cmsb [STG];

  logic ovf_q;
  logic ops_unused;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;

  for (genvar k = 0; k < STG; k++) begin : g_stage
    localparam int LO = k * GS;
    logic [N-1:0] s_nx;

    if (k == 0) begin : g_head
      assign v_in[k] = in_valid;
      assign c_in[k] = sub | cin;
      assign a_in[k] = a;
      assign b_in[k] = b_eff;
      assign s_in[k] = '0;
    end else begin : g_link
      assign v_in[k] = v_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign s_in[k] = s_q[k-1];
    end

    cla_group #(.GS(GS)) u_group (
      .a        (a_in[k][LO +: GS]),
      .b        (b_in[k][LO +: GS]),
      .cin      (c_in[k]),
      .sum      (g_sum[k]),
      .cout     (g_cout[k]),
      .c_msb_in (g_cmsb[k])
    );

    always_comb begin
      s_nx = s_in[k];
      s_nx[LO +: GS] = g_sum[k];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end else if (adv) begin
        v_q[k] <= v_in[k];
        c_q[k] <= g_cout[k];
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        s_q[k] <= s_nx;
      end
    end
  end

  // Overflow is carry-into-MSB xor carry-out-of-MSB, both in the last group.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= g_cout[STG-1] ^ g_cmsb[STG-1];
    end
  end

  // The final stage has no successor for its operand copies.
  assign ops_unused = ^{a_q[STG-1], b_q[STG-1]};

  assign out_valid = v_q[STG-1];
  assign sum       = s_q[STG-1];
  assign cout      = c_q[STG-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed vector table, random streaming with a
// scoreboard, back-pressure, mid-flight reset and a width/group sweep.
module tb_cla_pipe_adder;

  localparam int N   = 32;
  localparam int GS  = 8;
  localparam int STG = N / GS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         sub = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  logic        sw_valid = 1'b0;
  logic        sw_sub = 1'b0;
  logic        sw_cin = 1'b0;
  logic        sw_rdy = 1'b1;
  logic [63:0] sw_a = '0;
  logic [63:0] sw_b = '0;
  logic        sw_ir  [3];
  logic        sw_ov  [3];
  logic        sw_co  [3];
  logic        sw_of  [3];
  logic [63:0] sw_sum [3];
  logic [15:0] s16;
  logic [63:0] s64;
  logic [7:0]  s8;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit sb_on   = 1'b0;
  bit lat_chk = 1'b0;
  bit fired   = 1'b0;

  logic [33:0] exp_q[$];
  int          acc_q[$];
  logic [65:0] sq[3][$];
  int          sc[3][$];
  int sw_n[3]   = '{16, 64, 8};
  int sw_stg[3] = '{4, 4, 1};

  typedef struct {
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vt[10];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  cla_pipe_adder #(.N(N), .GS(GS)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sub(sub),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  cla_pipe_adder #(.N(16), .GS(4)) u_sw16 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[0]), .sub(sw_sub),
    .a(sw_a[15:0]), .b(sw_b[15:0]), .cin(sw_cin), .out_valid(sw_ov[0]),
    .out_ready(sw_rdy), .sum(s16), .cout(sw_co[0]), .ovf(sw_of[0])
  );

  cla_pipe_adder #(.N(64), .GS(16)) u_sw64 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[1]), .sub(sw_sub),
    .a(sw_a), .b(sw_b), .cin(sw_cin), .out_valid(sw_ov[1]),
    .out_ready(sw_rdy), .sum(s64), .cout(sw_co[1]), .ovf(sw_of[1])
  );

  cla_pipe_adder #(.N(8), .GS(8)) u_sw8 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[2]), .sub(sw_sub),
    .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin), .out_valid(sw_ov[2]),
    .out_ready(sw_rdy), .sum(s8), .cout(sw_co[2]), .ovf(sw_of[2])
  );

  assign sw_sum[0] = {48'b0, s16};
  assign sw_sum[1] = s64;
  assign sw_sum[2] = {56'b0, s8};

  // ---------------- reference model ----------------
  // Returns {ovf, cout, sum}: plain n-bit arithmetic, overflow from operand signs.
  function automatic logic [65:0] model(input int n, input logic [63:0] x, input logic [63:0] y,
                                        input logic ci, input logic sb);
    logic [63:0] mask;
    logic [63:0] xa;
    logic [63:0] yb;
    logic [63:0] s;
    logic [64:0] full;
    logic        co;
    logic        ov;
    mask = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    xa   = x & mask;
    yb   = (sb ? ~y : y) & mask;
    full = {1'b0, xa} + {1'b0, yb} + {64'b0, (sb | ci)};
    s    = full[63:0] & mask;
    co   = full[n];
    ov   = (xa[n-1] == yb[n-1]) && (s[n-1] != xa[n-1]);
    return {ov, co, s};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input bit iv, input bit ordy, output bit ir);
    if (!in_valid || fired) begin
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
    end
    in_valid  = iv;
    out_ready = ordy;
    @(negedge clk);
    ir    = in_ready;
    fired = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboards ----------------
  task automatic mon_main();
    logic [65:0] m;
    logic [33:0] e;
    int t;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        acc_q.delete();
      end else if (sb_on) begin
        if (in_valid && in_ready) begin
          m = model(N, {32'b0, a}, {32'b0, b}, cin, sub);
          exp_q.push_back({m[65], m[64], m[31:0]});
          acc_q.push_back(cyc);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("main_unexpected_out", 64'(out_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            t = acc_q.pop_front();
            chk("main_sum", 64'(sum), 64'(e[31:0]));
            chk("main_cout", 64'(cout), 64'(e[32]));
            chk("main_ovf", 64'(ovf), 64'(e[33]));
            if (lat_chk) chk("main_latency", 64'(cyc - t), 64'(STG));
          end
        end
      end
    end
  endtask

  task automatic mon_sweep();
    logic [65:0] e;
    int t;
    forever begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        if (rst) begin
          sq[j].delete();
          sc[j].delete();
        end else begin
          if (sw_valid && sw_ir[j]) begin
            sq[j].push_back(model(sw_n[j], sw_a, sw_b, sw_cin, sw_sub));
            sc[j].push_back(cyc);
          end
          if (sw_ov[j]) begin
            if (sq[j].size() == 0) begin
              chk($sformatf("sw%0d_unexpected_out", sw_n[j]), 64'(sw_ov[j]), 64'd0);
            end else begin
              e = sq[j].pop_front();
              t = sc[j].pop_front();
              chk($sformatf("sw%0d_sum", sw_n[j]), sw_sum[j], e[63:0]);
              chk($sformatf("sw%0d_cout", sw_n[j]), 64'(sw_co[j]), 64'(e[64]));
              chk($sformatf("sw%0d_ovf", sw_n[j]), 64'(sw_of[j]), 64'(e[65]));
              chk($sformatf("sw%0d_latency", sw_n[j]), 64'(cyc - t), 64'(sw_stg[j]));
            end
          end
        end
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [N-1:0] hs;
    logic hc;
    logic ho;
    bit   ir;
    int   n;

    vt[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vt[1] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vt[2] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vt[3] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vt[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
    vt[5] = '{1'b1, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vt[6] = '{1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vt[7] = '{1'b0, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
    vt[8] = '{1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vt[9] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    for (int j = 0; j < 3; j++) chk($sformatf("rst_sw%0d_out_valid", sw_n[j]), 64'(sw_ov[j]), 64'd0);

    fork
      mon_main();
      mon_sweep();
    join_none

    // Directed table: one op at a time, latency and result against constants.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sub = vt[i].sub;
      a   = vt[i].a;
      b   = vt[i].b;
      cin = vt[i].cin;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 12) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk($sformatf("vec%0d_latency", i), 64'(n), 64'(STG));
      chk($sformatf("vec%0d_sum", i), 64'(sum), 64'(vt[i].sum));
      chk($sformatf("vec%0d_cout", i), 64'(cout), 64'(vt[i].cout));
      chk($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vt[i].ovf));
      @(posedge clk);
      #1;
    end

    // Back-to-back random stream, full throughput.
    sb_on   = 1'b1;
    lat_chk = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_cycle(1'b1, 1'b1, ir);
      chk("stream_in_ready", 64'(ir), 64'd1);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("stream_drain", 64'(exp_q.size()), 64'd0);
    lat_chk = 1'b0;

    // Back-pressure with a full pipe.
    repeat (8) drive_cycle(1'b1, 1'b1, ir);
    chk("bp_full", 64'(out_valid), 64'd1);
    hs = sum;
    hc = cout;
    ho = ovf;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0, ir);
      chk("bp_in_ready", 64'(ir), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_sum_hold", 64'(sum), 64'(hs));
      chk("bp_cout_hold", 64'(cout), 64'(hc));
      chk("bp_ovf_hold", 64'(ovf), 64'(ho));
    end
    repeat (5) drive_cycle(1'b1, 1'b1, ir);
    in_valid = 1'b0;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("bp_drain", 64'(exp_q.size()), 64'd0);

    // Reset with three ops in flight: none of them may ever emerge.
    repeat (3) drive_cycle(1'b1, 1'b1, ir);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 1'b1, ir);
      chk("flush_quiet", 64'(out_valid), 64'd0);
    end

    // Parameter sweep: random ops with bubbles into 16/4, 64/16 and 8/8.
    for (int i = 0; i < 80; i++) begin
      sw_valid = ($urandom_range(0, 3) != 0);
      sw_a     = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
      sw_b     = {$urandom, $urandom};
      sw_cin   = 1'($urandom_range(0, 1));
      sw_sub   = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    sw_valid = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    for (int j = 0; j < 3; j++) chk($sformatf("sw%0d_drain", sw_n[j]), 64'(sq[j].size()), 64'd0);
    chk("main_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
